// File: rtl/rdi_clk_req_arbiter_if.sv
// Bundle of requester, grant and clk_handshake signals shared by the RDI clock-request arbiter.
// The slave side is the arbiter; the master side is the requesters plus the clk_handshake block.
interface rdi_clk_req_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] i_req;
    logic [NUM_REQ-1:0] o_gnt;
    logic               o_hs_en;
    logic               i_hs_awake;
    logic               i_err_clr;
    logic               o_awake;
    logic               o_timeout_err;

    modport slave (
        input  i_req,
        input  i_hs_awake,
        input  i_err_clr,
        output o_gnt,
        output o_hs_en,
        output o_awake,
        output o_timeout_err
    );

    modport master (
        output i_req,
        output i_hs_awake,
        output i_err_clr,
        input  o_gnt,
        input  o_hs_en,
        input  o_awake,
        input  o_timeout_err
    );
endinterface

// File: rtl/rdi_clk_req_arbiter.sv
// Shares one adapter-clock wake handshake among NUM_REQ requesters with round-robin grants,
// an idle hold window that reuses an awake clock, and a sticky wake-timeout flag.
module rdi_clk_req_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int HOLD_CYCLES  = 8,
    parameter int WAKE_TIMEOUT = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    rdi_clk_req_arbiter_if.slave  bus
);
    localparam int CNT_MAX = (WAKE_TIMEOUT > HOLD_CYCLES) ? WAKE_TIMEOUT : HOLD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int PW      = $clog2(NUM_REQ);

    localparam logic [CW-1:0]      WAKE_LAST = CW'(WAKE_TIMEOUT - 1);
    localparam logic [CW-1:0]      HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0]      PTR_RESET = PW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE       = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        WAKE,
        GRANT,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               hs_en_q, hs_en_d;
    logic               awake_q, awake_d;
    logic               err_q, err_d;
    logic [PW-1:0]      ptr_q, ptr_d;

    logic [PW-1:0]      win_idx;
    logic               win_valid;
    logic [NUM_REQ-1:0] win_onehot;
    logic               any_req;
    int                 idx;

    assign any_req = |bus.i_req;

    // Round-robin search starts just after the last granted index, so the current holder goes last.
    always_comb begin
        win_idx   = ptr_q;
        win_valid = 1'b0;
        idx       = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!win_valid && bus.i_req[idx]) begin
                win_valid = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    assign win_onehot = ONE << win_idx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        hs_en_d = hs_en_q;
        awake_d = awake_q;
        err_d   = bus.i_err_clr ? 1'b0 : err_q;
        ptr_d   = ptr_q;

        case (state_q)
            IDLE: begin
                gnt_d   = '0;
                hs_en_d = 1'b0;
                awake_d = 1'b0;
                if (any_req && !err_q) begin
                    state_d = WAKE;
                    hs_en_d = 1'b1;
                    cnt_d   = '0;
                end
            end

            WAKE: begin
                hs_en_d = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                if (bus.i_hs_awake) begin
                    hs_en_d = 1'b0;
                    awake_d = 1'b1;
                    if (win_valid) begin
                        state_d = GRANT;
                        gnt_d   = win_onehot;
                        ptr_d   = win_idx;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == WAKE_LAST) begin
                    state_d = IDLE;
                    hs_en_d = 1'b0;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end
            end

            GRANT: begin
                // ptr_q is the holder, so a released holder is never picked again by the search.
                if (!(|(bus.i_req & gnt_q))) begin
                    if (win_valid) begin
                        gnt_d = win_onehot;
                        ptr_d = win_idx;
                    end else begin
                        state_d = HOLD;
                        gnt_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end

            HOLD: begin
                gnt_d   = '0;
                awake_d = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                if (win_valid) begin
                    state_d = GRANT;
                    gnt_d   = win_onehot;
                    ptr_d   = win_idx;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                    awake_d = 1'b0;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            hs_en_q <= 1'b0;
            awake_q <= 1'b0;
            err_q   <= 1'b0;
            ptr_q   <= PTR_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            hs_en_q <= hs_en_d;
            awake_q <= awake_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.o_gnt         = gnt_q;
    assign bus.o_hs_en       = hs_en_q;
    assign bus.o_awake       = awake_q;
    assign bus.o_timeout_err = err_q;

endmodule

// File: tb/tb_rdi_clk_req_arbiter.sv
// Self-checking bench for rdi_clk_req_arbiter: table-driven vectors plus a hand-written timeout
// sequence, with expected outputs queued at drive time and popped one edge later.
module tb_rdi_clk_req_arbiter;
    localparam int NUM_REQ      = 4;
    localparam int HOLD_CYCLES  = 8;
    localparam int WAKE_TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rdi_clk_req_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    rdi_clk_req_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .HOLD_CYCLES (HOLD_CYCLES),
        .WAKE_TIMEOUT(WAKE_TIMEOUT)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus.slave)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       awake;
        logic       clr;
        logic [3:0] gnt;
        logic       hs_en;
        logic       aw;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   step_no      = 0;

    function automatic void add(input logic r, input logic [3:0] req, input logic awk, input logic clr,
                                input logic [3:0] gnt, input logic hs, input logic aw, input logic err);
        vec_t v;
        v.rst = r; v.req = req; v.awake = awk; v.clr = clr;
        v.gnt = gnt; v.hs_en = hs; v.aw = aw; v.err = err;
        vecs.push_back(v);
    endfunction

    task automatic compare(input string nm, input logic [3:0] act, input logic [3:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s step %0d: got %b, expected %b", nm, step_no, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge, so they are stable well before the next sampling edge.
    task automatic apply_stimulus(input vec_t v);
        rst            = v.rst;
        bus.i_req      = v.req;
        bus.i_hs_awake = v.awake;
        bus.i_err_clr  = v.clr;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
    endtask

    task automatic check_output();
        vec_t e;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL scoreboard step %0d: got empty queue, expected an entry", step_no);
        end else begin
            e = exp_q.pop_front();
            compare("o_gnt", bus.o_gnt, e.gnt);
            compare("o_hs_en", {3'b0, bus.o_hs_en}, {3'b0, e.hs_en});
            compare("o_awake", {3'b0, bus.o_awake}, {3'b0, e.aw});
            compare("o_timeout_err", {3'b0, bus.o_timeout_err}, {3'b0, e.err});
        end
        step_no++;
    endtask

    task automatic step(input logic r, input logic [3:0] req, input logic awk, input logic clr,
                        input logic [3:0] gnt, input logic hs, input logic aw, input logic err);
        vec_t v;
        v.rst = r; v.req = req; v.awake = awk; v.clr = clr;
        v.gnt = gnt; v.hs_en = hs; v.aw = aw; v.err = err;
        apply_stimulus(v);
        check_output();
    endtask

    initial begin
        rst            = 1'b1;
        bus.i_req      = '0;
        bus.i_hs_awake = 1'b0;
        bus.i_err_clr  = 1'b0;

        // Reset, stray wake in IDLE, then a handshake acknowledged on the fifth WAKE cycle.
        add(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 1, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b0001, 0, 0, 4'b0000, 1, 0, 0);
        repeat (4) add(0, 4'b0001, 0, 0, 4'b0000, 1, 0, 0);
        add(0, 4'b0001, 1, 0, 4'b0001, 0, 1, 0);
        // Back-to-back round robin 0,1,2,3,0 with no gap.
        add(0, 4'b1110, 0, 0, 4'b0010, 0, 1, 0);
        add(0, 4'b1101, 0, 0, 4'b0100, 0, 1, 0);
        add(0, 4'b1011, 0, 0, 4'b1000, 0, 1, 0);
        add(0, 4'b0111, 0, 0, 4'b0001, 0, 1, 0);
        // HOLD reuse: request on the fourth HOLD cycle, then a full idle window.
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 1, 0);
        repeat (3) add(0, 4'b0000, 0, 0, 4'b0000, 0, 1, 0);
        add(0, 4'b0100, 0, 0, 4'b0100, 0, 1, 0);
        add(0, 4'b0100, 0, 0, 4'b0100, 0, 1, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 1, 0);
        repeat (HOLD_CYCLES - 1) add(0, 4'b0000, 0, 0, 4'b0000, 0, 1, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
        // New handshake, acknowledged exactly on the last WAKE cycle.
        add(0, 4'b1000, 0, 0, 4'b0000, 1, 0, 0);
        repeat (WAKE_TIMEOUT - 1) add(0, 4'b1000, 0, 0, 4'b0000, 1, 0, 0);
        add(0, 4'b1000, 1, 0, 4'b1000, 0, 1, 0);
        // Reset with requester 1 granted, then pointer restarts so 1 then 3 win.
        add(0, 4'b0010, 0, 0, 4'b0010, 0, 1, 0);
        add(1, 4'b0010, 0, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b1010, 0, 0, 4'b0000, 1, 0, 0);
        add(0, 4'b1010, 1, 0, 4'b0010, 0, 1, 0);
        add(0, 4'b1000, 0, 0, 4'b1000, 0, 1, 0);
        // Request arriving on the final HOLD cycle beats the expiry.
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 1, 0);
        repeat (HOLD_CYCLES - 1) add(0, 4'b0000, 0, 0, 4'b0000, 0, 1, 0);
        add(0, 4'b0100, 0, 0, 4'b0100, 0, 1, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            check_output();
        end

        // Wake timeout: enable high for exactly WAKE_TIMEOUT cycles, then the sticky error blocks requests.
        step(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
        step(0, 4'b0001, 0, 0, 4'b0000, 1, 0, 0);
        for (int i = 0; i < WAKE_TIMEOUT - 1; i++) step(0, 4'b0001, 0, 0, 4'b0000, 1, 0, 0);
        step(0, 4'b0001, 0, 0, 4'b0000, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 4'b0001, 0, 0, 4'b0000, 0, 0, 1);
        step(0, 4'b0001, 0, 1, 4'b0000, 0, 0, 0);
        step(0, 4'b0001, 0, 0, 4'b0000, 1, 0, 0);
        for (int i = 0; i < WAKE_TIMEOUT - 1; i++) step(0, 4'b0001, 0, 0, 4'b0000, 1, 0, 0);
        // Clear on the timeout cycle itself: the new error wins.
        step(0, 4'b0001, 0, 1, 4'b0000, 0, 0, 1);
        step(0, 4'b0000, 0, 1, 4'b0000, 0, 0, 0);
        step(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
